// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares a single Booth multiplier among N_REQ clients.
// A watchdog aborts any multiplication that fails to complete.
module booth_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 40
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_abort,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_error,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr, r_cur_id, w_win_id, w_ptr_nxt;
  logic [N_REQ-1:0]   w_grant;
  logic               w_any, w_timeout;
  logic [CW-1:0]      r_wd_cnt;
  logic [WIDTH-1:0]   r_mul_a, r_mul_b;
  logic [2*WIDTH-1:0] r_rsp_product;
  logic               r_rsp_error;

  // First asserted request at or after the rotating pointer wins.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    idx      = 0;
    w_grant  = '0;
    w_win_id = '0;
    w_any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_any && req_valid[idx]) begin
        w_any        = 1'b1;
        w_win_id     = IDW'(idx);
        w_grant[idx] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_win_id == IDW'(N_REQ - 1)) ? '0 : w_win_id + IDW'(1);
  assign w_timeout = (r_wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    mul_start   = 1'b0;
    mul_abort   = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = w_grant;
        if (w_any) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mul_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the watchdog's final cycle still counts as success.
        if (mul_done) begin
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          mul_abort   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_cur_id      <= '0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_wd_cnt      <= '0;
      r_rsp_product <= '0;
      r_rsp_error   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_mul_a  <= req_a[w_win_id*WIDTH +: WIDTH];
            r_mul_b  <= req_b[w_win_id*WIDTH +: WIDTH];
            r_cur_id <= w_win_id;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        S_ISSUE: r_wd_cnt <= '0;
        S_WAIT: begin
          r_wd_cnt <= r_wd_cnt + CW'(1);
          if (mul_done) begin
            r_rsp_product <= mul_product;
            r_rsp_error   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_product <= '0;
            r_rsp_error   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign rsp_id      = r_cur_id;
  assign rsp_product = r_rsp_product;
  assign rsp_error   = r_rsp_error;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural multiplier model.
// Expected grants and responses come from a round-robin reference and plain signed arithmetic.
module tb_booth_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TO  = 40;
  localparam int IDW = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           mul_start, mul_abort, mul_done;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_product;
  logic           rsp_valid, rsp_error, busy;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_product;

  logic [W-1:0]   a_r [N];
  logic [W-1:0]   b_r [N];

  booth_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_abort(mul_abort),
    .mul_done(mul_done), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_r[i];
      req_b[i*W +: W] = b_r[i];
    end
  end

  typedef struct {
    int          id;
    logic [31:0] prod;
    bit          err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0, errors = 0;
  int          ptr = 0, cyc = 0, hs_cyc = 0, start_cyc = 0, abort_cyc = 0, done_cyc = 0;
  int          hs_count = 0, rsp_count = 0, lat_cfg = 12, next_lat = 0;
  bit          job_open = 0, abort_seen = 0, cur_err = 0;
  bit          hold_mode = 0, rand_mode = 0, spur_idle_req = 0, spur_issue = 0;
  bit [N-1:0]  hs_pending = '0;
  logic [W-1:0] cur_a = '0, cur_b = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x = $signed(a);
    longint y = $signed(b);
    return 32'(x * y);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Multiplier model: done appears on the L-th WAIT cycle after the start pulse; L = 0 never finishes.
  initial begin
    int  cnt;
    bit  active;
    logic [W-1:0] op_a, op_b;
    cnt = 0; active = 0; op_a = '0; op_b = '0;
    mul_done = 1'b0; mul_product = '0;
    forever begin
      @(posedge clock); #1;
      mul_done = 1'b0;
      mul_product = '0;
      if (reset) begin
        active = 0;
      end else begin
        if (mul_start) begin
          cnt = next_lat; active = (next_lat > 0); op_a = mul_a; op_b = mul_b;
          if (spur_issue) begin
            spur_issue = 0; mul_done = 1'b1; mul_product = 32'hDEADBEEF;
          end
        end else if (active) begin
          cnt--;
          if (cnt == 0) begin
            active = 0; mul_done = 1'b1; mul_product = smul(op_a, op_b);
          end
        end
        if (spur_idle_req) begin
          spur_idle_req = 0; mul_done = 1'b1; mul_product = 32'hBAD00BAD;
        end
      end
    end
  end

  // Request driver: a granted requester drops valid unless every client is holding on purpose.
  initial begin
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (hs_pending[i]) begin
          hs_pending[i] = 1'b0;
          if (!hold_mode) req_valid[i] = 1'b0;
        end
        if (rand_mode && !req_valid[i] && $urandom_range(0, 3) == 0) begin
          a_r[i] = 16'($urandom);
          b_r[i] = 16'($urandom);
          req_valid[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: reference grant model, scoreboard push on handshake, pop on response.
  always @(negedge clock) begin : mon
    int w, lat;
    bit err;
    logic [N-1:0] exp_ready;
    cyc++;
    if (!reset) begin
      w = rr_pick(req_valid, ptr);
      exp_ready = '0;
      if (!job_open && w >= 0) exp_ready[w] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(job_open));
      if (!job_open && w >= 0 && (req_valid & req_ready) != '0) begin
        if (lat_cfg < 0) lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
        else             lat = lat_cfg;
        err = (lat == 0) || (lat > TO);
        sb_q.push_back('{id: w, prod: err ? 32'h0 : smul(a_r[w], b_r[w]), err: err});
        next_lat = lat; cur_err = err; abort_seen = 0;
        cur_a = a_r[w]; cur_b = b_r[w];
        ptr = (w + 1) % N;
        job_open = 1; hs_cyc = cyc; hs_pending[w] = 1'b1; hs_count++;
      end
      if (mul_done) done_cyc = cyc;
      if (mul_start) begin
        check("start timing", 64'(cyc - hs_cyc), 64'(1));
        check("mul_a", 64'(mul_a), 64'(cur_a));
        check("mul_b", 64'(mul_b), 64'(cur_b));
        start_cyc = cyc;
      end
      if (mul_abort) begin
        check("abort expected", 64'(cur_err), 64'(1));
        check("abort timing", 64'(cyc - start_cyc), 64'(TO));
        abort_seen = 1; abort_cyc = cyc;
      end
      if (rsp_valid) begin
        check("rsp outstanding", 64'(sb_q.size()), 64'(1));
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_product", 64'(rsp_product), 64'(e.prod));
          check("rsp_error", 64'(rsp_error), 64'(e.err));
          check("mul_a held", 64'(mul_a), 64'(cur_a));
          if (e.err) begin
            check("abort seen", 64'(abort_seen), 64'(1));
            check("rsp after abort", 64'(cyc - abort_cyc), 64'(1));
          end else begin
            check("rsp after done", 64'(cyc - done_cyc), 64'(1));
          end
        end
        job_open = 0; rsp_count++;
      end
    end
  end

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_count < target && n < budget) begin
      @(posedge clock); n++;
    end
    check("rsp count", 64'(rsp_count), 64'(target));
  endtask

  task automatic check_reset_outputs();
    check("rst req_ready", 64'(req_ready), 64'(0));
    check("rst mul_start", 64'(mul_start), 64'(0));
    check("rst mul_abort", 64'(mul_abort), 64'(0));
    check("rst rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst rsp_error", 64'(rsp_error), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst mul_a", 64'(mul_a), 64'(0));
    check("rst mul_b", 64'(mul_b), 64'(0));
    check("rst rsp_id", 64'(rsp_id), 64'(0));
    check("rst rsp_product", 64'(rsp_product), 64'(0));
  endtask

  initial begin
    int n, target;
    for (int i = 0; i < N; i++) begin a_r[i] = '0; b_r[i] = '0; end
    #1 check_reset_outputs();
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    // All four requesting continuously: grant order 0,1,2,3,0.
    hold_mode = 1; lat_cfg = 12;
    @(posedge clock); #2;
    for (int i = 0; i < N; i++) begin a_r[i] = 16'(i + 1); b_r[i] = 16'd10; end
    req_valid = '1;
    n = 0;
    while (hs_count < 5 && n < 400) begin @(posedge clock); #2; n++; end
    req_valid = '0; hold_mode = 0;
    wait_rsp(5, 200);

    // Single requester 2: 3 * -5.
    lat_cfg = 18;
    @(posedge clock); #2;
    a_r[2] = 16'd3; b_r[2] = 16'hFFFB; req_valid[2] = 1'b1;
    wait_rsp(6, 100);

    // Multiplier never finishes: watchdog abort.
    lat_cfg = 0;
    @(posedge clock); #2;
    a_r[0] = 16'h1234; b_r[0] = 16'h0042; req_valid[0] = 1'b1;
    wait_rsp(7, 100);

    // Done on the final watchdog cycle wins over the abort.
    lat_cfg = TO;
    @(posedge clock); #2;
    a_r[1] = 16'd10; b_r[1] = 16'd10; req_valid[1] = 1'b1;
    wait_rsp(8, 100);

    // Spurious done while idle, then during ISSUE.
    @(posedge clock); #2;
    spur_idle_req = 1;
    repeat (4) @(posedge clock);
    #2;
    spur_issue = 1; lat_cfg = 6;
    a_r[3] = 16'hFFF9; b_r[3] = 16'd300; req_valid[3] = 1'b1;
    wait_rsp(9, 100);

    // Randomized traffic with random latencies and occasional hangs.
    lat_cfg = -1; rand_mode = 1;
    wait_rsp(34, 25 * 60);
    rand_mode = 0;
    n = 0;
    while ((req_valid != '0 || job_open) && n < 2000) begin @(posedge clock); n++; end
    check("drain", 64'(req_valid), 64'(0));

    // Reset in the middle of WAIT: job dropped silently, pointer back to 0.
    lat_cfg = 0;
    @(posedge clock); #2;
    target = hs_count + 1;
    a_r[2] = 16'd5; b_r[2] = 16'd6; req_valid[2] = 1'b1;
    n = 0;
    while (hs_count < target && n < 50) begin @(posedge clock); n++; end
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1 check_reset_outputs();
    sb_q.delete(); job_open = 0; ptr = 0; req_valid = '0; hs_pending = '0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    lat_cfg = 8;
    target = rsp_count + 2;
    @(posedge clock); #2;
    a_r[1] = 16'd7; b_r[1] = 16'hFFFF; a_r[3] = 16'd9; b_r[3] = 16'd9;
    req_valid = 4'b1010;
    wait_rsp(target, 100);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
